quickq_prio_queue: RTL and testbench

- Parametrised successor to the QuickQ core: a sorted, shift-register priority queue of DEPTH key/data entries.
- Generalised key width, data width, depth and ordering mode (min-first or max-first).
- Adds stable tie ordering, single-cycle simultaneous enqueue+dequeue (replace), runtime capacity limit, and drop/underflow flags.
- Sits between the scheduler front end and the QuickQ consumers; the head entry is always presented on the outputs.

---
 rtl/quickq_prio_queue.sv | 135 +++++++++++++
 tb/tb_quickq_prio_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/quickq_prio_queue.sv
// rtl/quickq_prio_queue.sv - sorted shift-register priority queue with stable ties, replace and capacity limit
module quickq_prio_queue #(
    parameter int KEY_W     = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int MAX_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [KEY_W-1:0]  enq_key,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    input  logic [7:0]        array_size,
    output logic              head_valid,
    output logic [KEY_W-1:0]  head_key,
    output logic [DATA_W-1:0] head_data,
    output logic [7:0]        count,
    output logic              full,
    output logic              empty,
    output logic              enq_drop,
    output logic              deq_err
);

    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    logic [DEPTH-1:0]  vld_q;
    logic [KEY_W-1:0]  key_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [7:0]        cnt_q;
    logic              drop_q;
    logic              err_q;

    logic [DEPTH-1:0]  b_vld;
    logic [KEY_W-1:0]  b_key  [DEPTH];
    logic [DATA_W-1:0] b_data [DEPTH];
    logic [DEPTH-1:0]  n_vld;
    logic [KEY_W-1:0]  n_key  [DEPTH];
    logic [DATA_W-1:0] n_data [DEPTH];

    logic [7:0] limit;
    logic       deq_ok;
    logic       enq_ok;
    logic       found;
    int         pos;

    function automatic logic better(input logic [KEY_W-1:0] x, input logic [KEY_W-1:0] y);
        return (MAX_FIRST != 0) ? (x > y) : (x < y);
    endfunction

    assign limit  = (array_size == 8'd0 || array_size > DEPTH_C) ? DEPTH_C : array_size;
    assign deq_ok = deq && (cnt_q != 8'd0);
    // A replace is always accepted, even when the queue sits above its limit.
    assign enq_ok = enq && ((cnt_q < limit) || deq_ok);

    always_comb begin
        b_vld  = vld_q;
        b_key  = key_q;
        b_data = data_q;
        if (deq_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                b_vld[i]  = vld_q[i+1];
                b_key[i]  = key_q[i+1];
                b_data[i] = data_q[i+1];
            end
            b_vld[DEPTH-1]  = 1'b0;
            b_key[DEPTH-1]  = '0;
            b_data[DEPTH-1] = '0;
        end

        // Strict comparison puts the newcomer behind every equal key.
        pos   = deq_ok ? int'(cnt_q) - 1 : int'(cnt_q);
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && b_vld[i] && better(enq_key, b_key[i])) begin
                pos   = i;
                found = 1'b1;
            end
        end

        n_vld  = b_vld;
        n_key  = b_key;
        n_data = b_data;
        if (enq_ok) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (i > pos) begin
                    n_vld[i]  = b_vld[i-1];
                    n_key[i]  = b_key[i-1];
                    n_data[i] = b_data[i-1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (i == pos) begin
                    n_vld[i]  = 1'b1;
                    n_key[i]  = enq_key;
                    n_data[i] = enq_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= '0;
            cnt_q  <= 8'd0;
            drop_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= n_vld;
            key_q  <= n_key;
            data_q <= n_data;
            if (enq_ok && !deq_ok) begin
                cnt_q <= cnt_q + 8'd1;
            end else if (deq_ok && !enq_ok) begin
                cnt_q <= cnt_q - 8'd1;
            end
            drop_q <= enq && !enq_ok;
            err_q  <= deq && (cnt_q == 8'd0);
        end
    end

    assign head_valid = vld_q[0];
    assign head_key   = vld_q[0] ? key_q[0] : '0;
    assign head_data  = vld_q[0] ? data_q[0] : '0;
    assign count      = cnt_q;
    assign full       = cnt_q >= limit;
    assign empty      = cnt_q == 8'd0;
    assign enq_drop   = drop_q;
    assign deq_err    = err_q;

endmodule

// File: tb/tb_quickq_prio_queue.sv
// tb/tb_quickq_prio_queue.sv - self-checking bench for quickq_prio_queue (min and max mode instances)
module tb_quickq_prio_queue;

    localparam int KW = 16;
    localparam int DW = 16;
    localparam int DP = 4;

    typedef struct {
        logic [KW-1:0] key;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq;
    logic [KW-1:0] enq_key;
    logic [DW-1:0] enq_data;
    logic          deq;
    logic [7:0]    array_size;

    logic          hv [2];
    logic [KW-1:0] hk [2];
    logic [DW-1:0] hd [2];
    logic [7:0]    cnt [2];
    logic          fl [2];
    logic          em [2];
    logic          dr [2];
    logic          er [2];

    ent_t mq [2][$];
    logic exp_drop [2];
    logic exp_err  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quickq_prio_queue #(.KEY_W(KW), .DATA_W(DW), .DEPTH(DP), .MAX_FIRST(0)) u_min (
        .clk(clk), .rst(rst), .enq(enq), .enq_key(enq_key), .enq_data(enq_data),
        .deq(deq), .array_size(array_size), .head_valid(hv[0]), .head_key(hk[0]),
        .head_data(hd[0]), .count(cnt[0]), .full(fl[0]), .empty(em[0]),
        .enq_drop(dr[0]), .deq_err(er[0])
    );

    quickq_prio_queue #(.KEY_W(KW), .DATA_W(DW), .DEPTH(DP), .MAX_FIRST(1)) u_max (
        .clk(clk), .rst(rst), .enq(enq), .enq_key(enq_key), .enq_data(enq_data),
        .deq(deq), .array_size(array_size), .head_valid(hv[1]), .head_key(hk[1]),
        .head_data(hd[1]), .count(cnt[1]), .full(fl[1]), .empty(em[1]),
        .enq_drop(dr[1]), .deq_err(er[1])
    );

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[mode%0d]: observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    // Head = best key, earliest arrival among equals; queue is kept in arrival order.
    function automatic int head_idx(input int m);
        int best = 0;
        for (int i = 1; i < mq[m].size(); i++) begin
            if (m == 1 ? (mq[m][i].key > mq[m][best].key) : (mq[m][i].key < mq[m][best].key))
                best = i;
        end
        return best;
    endfunction

    function automatic int lim();
        return (array_size == 0 || int'(array_size) > DP) ? DP : int'(array_size);
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int  n = mq[m].size();
            bit  d, a;
            if (!rst) begin
                mq[m].delete();
                exp_drop[m] = 1'b0;
                exp_err[m]  = 1'b0;
            end else begin
                d = deq && n > 0;
                a = enq && (n < lim() || d);
                exp_drop[m] = enq && !a;
                exp_err[m]  = deq && n == 0;
                if (d) mq[m].delete(head_idx(m));
                if (a) mq[m].push_back('{key: enq_key, data: enq_data});
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int n = mq[m].size();
            int h;
            chk("count", m, 32'(cnt[m]), 32'(n));
            chk("head_valid", m, 32'(hv[m]), 32'(n > 0));
            chk("empty", m, 32'(em[m]), 32'(n == 0));
            chk("full", m, 32'(fl[m]), 32'(n >= lim()));
            chk("enq_drop", m, 32'(dr[m]), 32'(exp_drop[m]));
            chk("deq_err", m, 32'(er[m]), 32'(exp_err[m]));
            if (n > 0) begin
                h = head_idx(m);
                chk("head_key", m, 32'(hk[m]), 32'(mq[m][h].key));
                chk("head_data", m, 32'(hd[m]), 32'(mq[m][h].data));
            end else begin
                chk("head_key", m, 32'(hk[m]), 32'd0);
                chk("head_data", m, 32'(hd[m]), 32'd0);
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [KW-1:0] k,
                        input logic [DW-1:0] dt, input logic q, input logic [7:0] sz);
        @(negedge clk);
        rst = r; enq = e; enq_key = k; enq_data = dt; deq = q; array_size = sz;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0; enq = 1'b0; enq_key = '0; enq_data = '0; deq = 1'b0; array_size = 8'd0;
        for (int m = 0; m < 2; m++) begin
            exp_drop[m] = 1'b0;
            exp_err[m]  = 1'b0;
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Underflow on an empty queue
        repeat (3) step(1, 0, 0, 0, 1, 0);

        // Sorted insert and drain
        step(1, 1, 4, 16'h41, 0, 0);
        step(1, 1, 2, 16'h21, 0, 0);
        step(1, 1, 9, 16'h91, 0, 0);
        repeat (3) step(1, 0, 0, 0, 1, 0);

        // Stable ties
        step(1, 1, 5, 16'hA, 0, 0);
        step(1, 1, 5, 16'hB, 0, 0);
        step(1, 1, 3, 16'hC, 0, 0);
        repeat (3) step(1, 0, 0, 0, 1, 0);

        // Capacity limit, drop, then replace while full
        step(1, 1, 7, 16'h7, 0, 3);
        step(1, 1, 3, 16'h3, 0, 3);
        step(1, 1, 8, 16'h8, 0, 3);
        step(1, 1, 1, 16'h1, 0, 3);
        step(1, 1, 1, 16'h1, 1, 3);
        // Lower the limit below count, then drain
        step(1, 1, 2, 16'h2, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        step(1, 1, 0, 16'h55, 1, 0);

        // Reset wins over enq; then restart
        step(0, 1, 6, 16'h6, 0, 0);
        step(1, 1, 6, 16'h6, 0, 0);

        // Enqueue plus dequeue on empty
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 9, 16'h99, 1, 0);

        // Random traffic with small keys to force ties
        for (int i = 0; i < 600; i++) begin
            logic [7:0] sz;
            int sel = $urandom_range(0, 9);
            sz = (sel < 6) ? 8'd0 : 8'($urandom_range(1, 6));
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 99) < 60),
                 KW'($urandom_range(0, 5)),
                 DW'($urandom),
                 1'($urandom_range(0, 99) < 45),
                 sz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
